// File: rtl/serial_pattern_tx.sv
// Frame-based serial bit-pattern transmitter: shifts a captured word out one bit per clock,
// follows each frame with a programmable idle gap, and optionally repeats the frame.
module serial_pattern_tx #(
    parameter int   WIDTH     = 8,
    parameter int   GAP       = 2,
    parameter logic IDLE_BIT  = 1'b0,
    parameter int   MSB_FIRST = 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [WIDTH-1:0]             data,
    input  logic [$clog2(WIDTH+1)-1:0]   len,
    input  logic                         loop,
    output logic                         A,
    output logic                         valid,
    output logic                         done,
    output logic                         ready
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_GAP
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [WIDTH-1:0] cap_data_q, cap_data_d;
    logic [CW-1:0]    cap_len_q, cap_len_d;
    logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [GW-1:0]    gap_cnt_q, gap_cnt_d;
    logic             a_q, a_d;
    logic             valid_q, valid_d;
    logic             done_q, done_d;

    logic             len_ok;
    logic             load_en;
    logic             frame_end;
    logic [WIDTH-1:0] load_word;
    logic [CW-1:0]    load_len;
    logic [WIDTH-1:0] aligned;

    // Left-justify an MSB-first frame so its first bit always sits at the top of the register.
    function automatic logic [WIDTH-1:0] align(input logic [WIDTH-1:0] w, input logic [CW-1:0] n);
        if (MSB_FIRST != 0) return w << (CW'(WIDTH) - n);
        return w;
    endfunction

    function automatic logic next_bit(input logic [WIDTH-1:0] w);
        return (MSB_FIRST != 0) ? w[WIDTH-1] : w[0];
    endfunction

    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
        return (MSB_FIRST != 0) ? (w << 1) : (w >> 1);
    endfunction

    assign len_ok = (len != '0) && (len <= CW'(WIDTH));

    always_comb begin
        state_d    = state_q;
        sreg_d     = sreg_q;
        cap_data_d = cap_data_q;
        cap_len_d  = cap_len_q;
        bit_cnt_d  = bit_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        a_d        = IDLE_BIT;
        valid_d    = 1'b0;
        done_d     = 1'b0;
        load_en    = 1'b0;
        frame_end  = 1'b0;
        load_word  = cap_data_q;
        load_len   = cap_len_q;

        case (state_q)
            S_IDLE: begin
                if (start && len_ok) begin
                    cap_data_d = data;
                    cap_len_d  = len;
                    load_word  = data;
                    load_len   = len;
                    load_en    = 1'b1;
                end
            end
            S_SHIFT: begin
                if (bit_cnt_q == CW'(1)) begin
                    done_d    = 1'b1;
                    bit_cnt_d = '0;
                    if (GAP > 0) begin
                        state_d   = S_GAP;
                        gap_cnt_d = GW'(GAP);
                    end else begin
                        frame_end = 1'b1;
                    end
                end else begin
                    a_d       = next_bit(sreg_q);
                    sreg_d    = advance(sreg_q);
                    valid_d   = 1'b1;
                    bit_cnt_d = bit_cnt_q - CW'(1);
                end
            end
            S_GAP: begin
                if (gap_cnt_q == GW'(1)) begin
                    gap_cnt_d = '0;
                    frame_end = 1'b1;
                end else begin
                    gap_cnt_d = gap_cnt_q - GW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Looping replays the captured word, never the live inputs.
        if (frame_end) begin
            if (loop) load_en = 1'b1;
            else      state_d = S_IDLE;
        end

        aligned = align(load_word, load_len);
        if (load_en) begin
            state_d   = S_SHIFT;
            a_d       = next_bit(aligned);
            sreg_d    = advance(aligned);
            valid_d   = 1'b1;
            bit_cnt_d = load_len;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            sreg_q     <= '0;
            cap_data_q <= '0;
            cap_len_q  <= '0;
            bit_cnt_q  <= '0;
            gap_cnt_q  <= '0;
            a_q        <= IDLE_BIT;
            valid_q    <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            sreg_q     <= sreg_d;
            cap_data_q <= cap_data_d;
            cap_len_q  <= cap_len_d;
            bit_cnt_q  <= bit_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            a_q        <= a_d;
            valid_q    <= valid_d;
            done_q     <= done_d;
        end
    end

    assign A     = a_q;
    assign valid = valid_q;
    assign done  = done_q;
    assign ready = (state_q == S_IDLE);

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Directed bench for serial_pattern_tx: a default instance (GAP=2, MSB first) and an
// alternate instance (GAP=0, LSB first) checked cycle by cycle against a scoreboard.
module tb_serial_pattern_tx;

    localparam logic [3:0] IDLE_O = 4'b0001;  // {A, valid, done, ready}

    logic       clk;
    logic       reset;
    logic       start, start2;
    logic [7:0] data;
    logic [3:0] len;
    logic       loop, loop2;
    logic       a_m, valid_m, done_m, ready_m;
    logic       a_2, valid_2, done_2, ready_2;

    int checks   = 0;
    int failures = 0;

    logic [3:0] sb_main[$];
    logic [3:0] sb_alt[$];

    serial_pattern_tx #(.WIDTH(8), .GAP(2), .IDLE_BIT(1'b0), .MSB_FIRST(1)) u_main (
        .clk(clk), .reset(reset), .start(start), .data(data), .len(len), .loop(loop),
        .A(a_m), .valid(valid_m), .done(done_m), .ready(ready_m)
    );

    serial_pattern_tx #(.WIDTH(8), .GAP(0), .IDLE_BIT(1'b0), .MSB_FIRST(0)) u_alt (
        .clk(clk), .reset(reset), .start(start2), .data(data), .len(len), .loop(loop2),
        .A(a_2), .valid(valid_2), .done(done_2), .ready(ready_2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input string tag);
        logic [3:0] e;
        logic [3:0] o;
        @(posedge clk);
        @(negedge clk);
        e = sb_main.pop_front();
        o = {a_m, valid_m, done_m, ready_m};
        checks++;
        assert (o === e) else begin
            failures++;
            $error("FAIL %s main observed=%b expected=%b", tag, o, e);
        end
        e = sb_alt.pop_front();
        o = {a_2, valid_2, done_2, ready_2};
        checks++;
        assert (o === e) else begin
            failures++;
            $error("FAIL %s alt observed=%b expected=%b", tag, o, e);
        end
    endtask

    task automatic cyc(input logic [3:0] em, input logic [3:0] ea, input string tag);
        sb_main.push_back(em);
        sb_alt.push_back(ea);
        tick(tag);
    endtask

    // seq lists the expected line bits in transmit order, seq[n-1] first.
    task automatic main_frame(input logic [7:0] d, input logic [3:0] n,
                              input logic [7:0] seq, input int poke);
        data  = d;
        len   = n;
        start = 1'b1;
        for (int i = 0; i < int'(n); i++) begin
            cyc({seq[int'(n) - 1 - i], 3'b100}, IDLE_O, "main_bit");
            start = 1'b0;
            if (i == poke) begin
                start = 1'b1;
                data  = 8'hFF;
                len   = 4'd8;
            end
        end
        start = 1'b0;
        cyc(4'b0010, IDLE_O, "main_gap1_done");
        cyc(4'b0000, IDLE_O, "main_gap2");
        cyc(IDLE_O, IDLE_O, "main_back_idle");
    endtask

    task automatic alt_frame(input logic [7:0] d, input logic [3:0] n, input logic [7:0] seq);
        data   = d;
        len    = n;
        start2 = 1'b1;
        for (int i = 0; i < int'(n); i++) begin
            cyc(IDLE_O, {seq[int'(n) - 1 - i], 3'b100}, "alt_bit");
            start2 = 1'b0;
        end
        cyc(IDLE_O, 4'b0011, "alt_done_idle");
        cyc(IDLE_O, IDLE_O, "alt_idle");
    endtask

    initial begin
        reset  = 1'b0;
        start  = 1'b0;
        start2 = 1'b0;
        data   = 8'h00;
        len    = 4'd0;
        loop   = 1'b0;
        loop2  = 1'b0;

        // Reset and quiescent idle
        repeat (2) cyc(IDLE_O, IDLE_O, "reset_state");
        reset = 1'b1;
        repeat (10) cyc(IDLE_O, IDLE_O, "idle_hold");

        // Full 8-bit frame, MSB first
        main_frame(8'b0100_1101, 4'd8, 8'b0100_1101, -1);

        // Short frame uses only the low len bits
        main_frame(8'hF5, 4'd3, 8'b0000_0101, -1);

        // Invalid lengths are ignored
        data  = 8'hA5;
        len   = 4'd0;
        start = 1'b1;
        repeat (2) cyc(IDLE_O, IDLE_O, "len_zero_ignored");
        len = 4'd9;
        repeat (2) cyc(IDLE_O, IDLE_O, "len_nine_ignored");
        start = 1'b0;

        // Start and data changes mid-frame are ignored
        main_frame(8'b0100_1101, 4'd8, 8'b0100_1101, 3);
        repeat (3) cyc(IDLE_O, IDLE_O, "no_requeue");

        // Loop mode replays the captured frame; dropping loop ends after the gap
        loop  = 1'b1;
        data  = 8'b0000_0101;
        len   = 4'd3;
        start = 1'b1;
        for (int f = 0; f < 3; f++) begin
            cyc(4'b1100, IDLE_O, "loop_bit0");
            start = 1'b0;
            if (f == 1) begin
                data = 8'h00;
                len  = 4'd8;
            end
            if (f == 2) loop = 1'b0;
            cyc(4'b0100, IDLE_O, "loop_bit1");
            cyc(4'b1100, IDLE_O, "loop_bit2");
            cyc(4'b0010, IDLE_O, "loop_gap1_done");
            cyc(4'b0000, IDLE_O, "loop_gap2");
        end
        cyc(IDLE_O, IDLE_O, "loop_released_idle");

        // Alternate instance: LSB first with no gap
        alt_frame(8'hF5, 4'd3, 8'b0000_0101);
        alt_frame(8'h0B, 4'd4, 8'b0000_1101);

        // Alternate instance: back-to-back looping frames
        loop2  = 1'b1;
        data   = 8'b0000_0101;
        len    = 4'd3;
        start2 = 1'b1;
        cyc(IDLE_O, 4'b1100, "alt_loop_f0b0");
        start2 = 1'b0;
        data   = 8'hFF;
        cyc(IDLE_O, 4'b0100, "alt_loop_f0b1");
        cyc(IDLE_O, 4'b1100, "alt_loop_f0b2");
        for (int f = 1; f < 3; f++) begin
            cyc(IDLE_O, 4'b1110, "alt_loop_b0_done");
            if (f == 2) loop2 = 1'b0;
            cyc(IDLE_O, 4'b0100, "alt_loop_b1");
            cyc(IDLE_O, 4'b1100, "alt_loop_b2");
        end
        cyc(IDLE_O, 4'b0011, "alt_loop_end_done");
        cyc(IDLE_O, IDLE_O, "alt_loop_idle");

        // Reset in the middle of a frame aborts it without a done pulse
        data  = 8'b0100_1101;
        len   = 4'd8;
        start = 1'b1;
        cyc(4'b0100, IDLE_O, "abort_bit1");
        start = 1'b0;
        cyc(4'b1100, IDLE_O, "abort_bit2");
        cyc(4'b0100, IDLE_O, "abort_bit3");
        cyc(4'b0100, IDLE_O, "abort_bit4");
        cyc(4'b1100, IDLE_O, "abort_bit5");
        reset = 1'b0;
        cyc(IDLE_O, IDLE_O, "abort_reset");
        reset = 1'b1;
        repeat (12) cyc(IDLE_O, IDLE_O, "abort_no_done");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
